uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM states and helpers for the UART message arbiter.
// Optional tag byte per message is enabled with UART_TX_ARB_TAG_EN.
package uart_pkg;

  localparam int         WORD_W   = 32;
  localparam logic [7:0] ASCII_NL = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    IDLE,
    TAG,
    DIGIT,
    NEWLINE
  } state_e;

  function automatic logic [7:0] to_hex(
    input logic [3:0] n
  );
    if (n < 4'd10) return ASCII_0 + {4'h0, n};
    return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select, searching upward from last_grant+1.
// Emits a one-hot grant and the matching index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  int   k;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req_valid[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter serialising 32-bit words as ASCII hex lines.
// UART_TX_ARB_TAG_EN prefixes each line with the requester digit.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      uart_tx_ready,
  output logic                      uart_new_byte,
  output logic [7:0]                uart_byte,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [7:0]          byte_q;
  logic                prev_q;
  logic [NUM_REQ-1:0]  rr_gnt;
  logic [ID_W-1:0]     rr_idx;
  logic                issue;
  logic [7:0]          chr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_valid  (req_valid),
    .last_grant (last_q),
    .gnt        (rr_gnt),
    .idx        (rr_idx)
  );

  // Strobe only into an idle transmitter, never back to back.
  assign issue = rst_n && (state_q != IDLE)
              && uart_tx_ready && !prev_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    chr     = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = rr_idx;
          last_d  = rr_idx;
          shreg_d = req_data[int'(rr_idx)*WORD_W +: WORD_W];
          cnt_d   = 4'd8;
`ifdef UART_TX_ARB_TAG_EN
          state_d = TAG;
`else
          state_d = DIGIT;
`endif
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      TAG: begin
        chr = ASCII_0 + 8'(grant_q);
        if (issue) state_d = DIGIT;
      end
`endif
      DIGIT: begin
        chr = to_hex(shreg_q[WORD_W-1 -: 4]);
        if (issue) begin
          shreg_d = {shreg_q[WORD_W-5:0], 4'h0};
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = NEWLINE;
        end
      end
      NEWLINE: begin
        chr = ASCII_NL;
        if (issue) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      byte_q  <= 8'h00;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      byte_q  <= uart_byte;
      prev_q  <= issue;
    end
  end

  assign req_ready = (rst_n && state_q == IDLE)
                   ? rr_gnt : '0;
  assign uart_new_byte = issue;
  assign uart_byte     = issue ? chr : byte_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter against a queue-based line model.
// Tag byte expectations follow UART_TX_ARB_TAG_EN.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;
`ifdef UART_TX_ARB_TAG_EN
  localparam int TAGB = 1;
`else
  localparam int TAGB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_rdy;
  logic          new_byte;
  logic [7:0]    ubyte;
  logic          busy;
  logic [IW-1:0] grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .uart_tx_ready (tx_rdy),
    .uart_new_byte (new_byte),
    .uart_byte     (ubyte),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] q[$];
  int         last_m   = N - 1;
  int         cur_g    = 0;
  int         msg_b    = 0;
  int         n_acc    = 0;
  logic [7:0] last_b   = 8'h00;
  logic       prev_nb  = 1'b0;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 10) ? 8'd48 + 8'(n) : 8'd55 + 8'(n);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v);
    for (int i = 1; i <= N; i++)
      if (v[(last_m + i) % N]) return (last_m + i) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_nb", new_byte, 0);
      chk("rst_byte", ubyte, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gid", grant_id, 0);
      q.delete();
      last_m  = N - 1;
      last_b  = 8'h00;
      prev_nb = 1'b0;
    end else begin
      automatic bit idle_m = (q.size() == 0);
      automatic int g;
      automatic logic [N-1:0] exp_r;
      automatic logic [31:0] w;
      chk("busy", busy, !idle_m);
      if (!idle_m) chk("grant_id", grant_id, cur_g);
      chk("tx_gate", new_byte && !tx_rdy, 0);
      chk("b2b", new_byte && prev_nb, 0);
      if (new_byte) begin
        if (q.size() == 0) chk("extra", new_byte, 0);
        else begin
          chk("byte", ubyte, q.pop_front());
          msg_b++;
        end
        last_b = ubyte;
      end else begin
        chk("hold", ubyte, last_b);
      end
      g = rr_pick(req_valid);
      exp_r = (idle_m && g >= 0) ? N'(1 << g) : '0;
      chk("req_ready", req_ready, exp_r);
      if (exp_r != 0) begin
        w = req_data[g*32 +: 32];
        if (TAGB == 1) q.push_back(8'd48 + 8'(g));
        for (int d = 7; d >= 0; d--)
          q.push_back(hexc(w[d*4 +: 4]));
        q.push_back(8'h0A);
        last_m = g;
        cur_g  = g;
        msg_b  = 0;
        n_acc++;
      end
      prev_nb = new_byte;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((q.size() != 0 || busy) && n < lim) begin
      step(1);
      n++;
    end
    chk("idle_timeout", busy, 0);
    chk("q_empty", q.size(), 0);
  endtask

  task automatic wait_acc(input int cnt, input int lim);
    int n = 0;
    while (n_acc < cnt && n < lim) begin
      step(1);
      n++;
    end
    chk("acc_timeout", n_acc >= cnt, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = {N*32{1'b1}};
    tx_rdy    = 1'b1;
    step(3);
    req_valid = '0;
    rst_n     = 1'b1;
    step(2);

    // single requester, fixed word
    req_data[31:0] = 32'h1234ABCD;
    req_valid = 3'b001;
    step(1);
    req_valid = '0;
    wait_idle(100);

    // all requesting, round robin
    req_data = {32'h9A000001, 32'hFFFFFFFF,
                32'h00000000};
    req_valid = '1;
    wait_acc(n_acc + 5, 200);
    req_valid = '0;
    wait_idle(100);

    // transmitter stall mid message
    req_data[95:64] = 32'h0000000A;
    req_valid = 3'b100;
    step(1);
    req_valid = '0;
    begin
      int n = 0;
      while (msg_b < 4 && n < 100) begin
        step(1);
        n++;
      end
    end
    tx_rdy = 1'b0;
    step(50);
    tx_rdy = 1'b1;
    wait_idle(100);

    // reset after the third digit
    req_data  = {3{32'hDEADBEEF}};
    req_valid = '1;
    begin
      int n = 0;
      while (!(busy && msg_b >= TAGB + 3) && n < 200) begin
        step(1);
        n++;
      end
    end
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    req_data[31:0] = 32'h00C0FFEE;
    begin
      int n = 0;
      while (req_ready == 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("post_rst_grant", req_ready, 3'b001);
    end
    step(1);
    req_valid = '0;
    wait_idle(100);

    // random traffic, data churns after accept
    for (int c = 0; c < 1500; c++) begin
      req_valid = N'($urandom);
      for (int r = 0; r < N; r++)
        req_data[r*32 +: 32] = $urandom;
      tx_rdy = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req_valid = '0;
    tx_rdy    = 1'b1;
    wait_idle(200);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
